imem_loader: RTL and testbench

//  Write-side initiator for the instruction memory port (memWriteIM/sr/write_data).

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader_word_packer.sv | 30 +++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// memory geometry and small state-classification helpers.
package imem_loader_pkg;

  localparam int IMEM_ADDR_BITS = 10;
  localparam int IMEM_WORDS     = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) ||
           (s == ST_WRITE) || (s == ST_CSUM);
  endfunction

  // States in which the loader takes bytes from the host link.
  function automatic logic takes_bytes(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus instruction-memory write port. The loader uses the
// master view; the host/memory side uses the slave view.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        memWriteIM;
  logic [31:0] sr;
  logic [31:0] write_data;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, memWriteIM, sr, write_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, memWriteIM, sr, write_data
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
// full flags the byte that completes the current word (combinational).
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        in_en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0] lane;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= 2'd0;
      word <= '0;
    end else if (clr) begin
      lane <= 2'd0;
    end else if (in_en) begin
      word[{lane, 3'b000} +: 8] <= in_byte;
      lane                      <= lane + 2'd1;
    end
  end

  // The lane counter wraps back to 0 on its own after the fourth byte.
  assign full = in_en && !clr && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed little-endian word stream into the
// instruction memory and holds the CPU in reset until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_BITS = IMEM_ADDR_BITS,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = IMEM_WORDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [ADDR_BITS-1:0] BASE_A = ADDR_BITS'(BASE_ADDR);
  localparam logic [16:0]          MAX_W  = 17'(MAX_WORDS);

  state_t                 state, next_state;
  logic [15:0]            len;
  logic [16:0]            wcnt;
  logic [ADDR_BITS-1:0]   addr;
  logic [7:0]             csum;
  logic                   ready;
  logic                   consume;
  logic                   clr;
  logic                   pk_en;
  logic                   pk_full;
  logic [31:0]            pk_word;
  logic [16:0]            len_hdr;

  assign ready   = takes_bytes(state);
  assign consume = bus.byte_valid && ready;
  assign pk_en   = consume && (state == ST_DATA);
  // Full 17-bit view of the length as it will be once the high byte lands.
  assign len_hdr = {1'b0, bus.byte_data, len[7:0]};

  word_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .in_en   (pk_en),
    .in_byte (bus.byte_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    clr        = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          next_state = ST_LEN0;
          clr        = 1'b1;
        end
      end
      ST_LEN0: if (consume) next_state = ST_LEN1;
      ST_LEN1: begin
        if (consume) begin
          if (len_hdr == 17'd0 || len_hdr > MAX_W) next_state = ST_ERR;
          else                                     next_state = ST_DATA;
        end
      end
      ST_DATA:  if (pk_full) next_state = ST_WRITE;
      ST_WRITE: begin
        if (wcnt + 17'd1 == {1'b0, len}) next_state = ST_CSUM;
        else                             next_state = ST_DATA;
      end
      ST_CSUM: begin
        if (consume) next_state = (bus.byte_data == csum) ? ST_DONE : ST_ERR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Load bookkeeping: length header, address, word count and running checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len  <= '0;
      wcnt <= '0;
      addr <= BASE_A;
      csum <= '0;
    end else if (clr) begin
      len  <= '0;
      wcnt <= '0;
      addr <= BASE_A;
      csum <= '0;
    end else begin
      if (consume && state == ST_LEN0) len[7:0]  <= bus.byte_data;
      if (consume && state == ST_LEN1) len[15:8] <= bus.byte_data;
      if (pk_en)                       csum      <= csum ^ bus.byte_data;
      if (state == ST_WRITE) begin
        addr <= addr + 1'b1;
        wcnt <= wcnt + 17'd1;
      end
    end
  end

  assign bus.byte_ready = ready;
  assign bus.memWriteIM = (state == ST_WRITE);
  assign bus.sr         = {{(32-ADDR_BITS){1'b0}}, addr};
  assign bus.write_data = pk_word;

  assign busy     = is_busy(state);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERR);
  assign cpu_hold = busy || error;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two loaders (base 0 and base 1022) share one byte
// stream; a transaction-level model predicts every memory write and outcome.
module tb_imem_loader;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       hold_a, busy_a, done_a, err_a;
  logic       hold_b, busy_b, done_b, err_b;

  int         n_cmp = 0;
  int         n_bad = 0;
  wr_t        qa[$], qb[$], la[$], lb[$];
  logic [7:0] stream[$];
  logic [7:0] model_cs;

  imem_loader_if ia ();
  imem_loader_if ib ();

  assign ia.byte_valid = byte_valid;
  assign ia.byte_data  = byte_data;
  assign ib.byte_valid = byte_valid;
  assign ib.byte_data  = byte_data;

  imem_loader #(.ADDR_BITS(10), .BASE_ADDR(0), .MAX_WORDS(1024)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(ia),
    .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .error(err_a)
  );

  imem_loader #(.ADDR_BITS(10), .BASE_ADDR(1022), .MAX_WORDS(1024)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(ib),
    .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .error(err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle checker: every write must be the next predicted one, and the
  // link must be ready in every busy cycle except the write cycle.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (ia.memWriteIM) begin
        la.push_back('{a: ia.sr, d: ia.write_data});
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write_a: sr=%h data=%h, expected no write", ia.sr, ia.write_data);
        end else begin
          e = qa.pop_front();
          chk("sr_a", ia.sr, e.a);
          chk("wdata_a", ia.write_data, e.d);
        end
        chk("ready_in_write_a", {31'd0, ia.byte_ready}, 32'd0);
        chk("hold_in_write_a", {31'd0, hold_a}, 32'd1);
      end else if (busy_a) begin
        chk("ready_busy_a", {31'd0, ia.byte_ready}, 32'd1);
      end
      if (ib.memWriteIM) begin
        lb.push_back('{a: ib.sr, d: ib.write_data});
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write_b: sr=%h data=%h, expected no write", ib.sr, ib.write_data);
        end else begin
          e = qb.pop_front();
          chk("sr_b", ib.sr, e.a);
          chk("wdata_b", ib.write_data, e.d);
        end
        chk("ready_in_write_b", {31'd0, ib.byte_ready}, 32'd0);
      end else if (busy_b) begin
        chk("ready_busy_b", {31'd0, ib.byte_ready}, 32'd1);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte after 'gap' idle cycles; returns just after the consuming edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!ia.byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_accept_timeout: byte %h not accepted within 100 cycles", b);
    end
    @(posedge clk);
  endtask

  task automatic run_load(input string tag, input bit start_while_busy, input int max_gap);
    int len, nw, n, gap;
    logic [7:0] cs;
    logic [31:0] w;
    bit exp_done;
    la.delete(); lb.delete(); qa.delete(); qb.delete();
    len = int'(stream[0]) + 256 * int'(stream[1]);
    nw  = (len == 0 || len > 1024) ? 0 : len;
    cs  = 8'h00;
    for (int i = 0; i < nw; i++) begin
      w  = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      qa.push_back('{a: 32'(i % 1024), d: w});
      qb.push_back('{a: 32'((1022 + i) % 1024), d: w});
    end
    exp_done = (nw > 0) && (stream[2+4*nw] == cs);
    model_cs = cs;

    pulse_start();
    for (int i = 0; i < stream.size(); i++) begin
      gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      send_byte(stream[i], gap);
      if (i == 0 && start_while_busy) pulse_start();
    end
    n = 0;
    do begin
      @(negedge clk);
      byte_valid = 1'b0;
      n++;
    end while (!(done_a || err_a) && n < 50);
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_finish_timeout: no done/error within 50 cycles", tag);
    end
    chk({tag, "_done_a"}, {31'd0, done_a}, {31'd0, exp_done});
    chk({tag, "_err_a"},  {31'd0, err_a},  {31'd0, !exp_done});
    chk({tag, "_hold_a"}, {31'd0, hold_a}, {31'd0, !exp_done});
    chk({tag, "_busy_a"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_done_b"}, {31'd0, done_b}, {31'd0, exp_done});
    chk({tag, "_err_b"},  {31'd0, err_b},  {31'd0, !exp_done});
    chk({tag, "_hold_b"}, {31'd0, hold_b}, {31'd0, !exp_done});
    chk({tag, "_pending_a"}, 32'(qa.size()), 32'd0);
    chk({tag, "_pending_b"}, 32'(qb.size()), 32'd0);
    chk({tag, "_nwrites_a"}, 32'(la.size()), 32'(nw));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_write",  {31'd0, ia.memWriteIM}, 32'd0);
    chk("rst_hold",   {31'd0, hold_a}, 32'd0);
    chk("rst_busy",   {31'd0, busy_a}, 32'd0);
    chk("rst_ready",  {31'd0, ia.byte_ready}, 32'd0);
    chk("rst_sr_b",   ib.sr, 32'd1022);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy_a}, 32'd0);

    // Asynchronous reset in the middle of a word
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("mid_busy_before", {31'd0, busy_a}, 32'd1);
    chk("mid_hold_before", {31'd0, hold_a}, 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy",  {31'd0, busy_a}, 32'd0);
    chk("arst_hold",  {31'd0, hold_a}, 32'd0);
    chk("arst_write", {31'd0, ia.memWriteIM}, 32'd0);
    chk("arst_ready", {31'd0, ia.byte_ready}, 32'd0);
    chk("arst_sr_a",  ia.sr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("arst_nowrites", 32'(la.size()), 32'd0);

    // Nominal two-word image; XOR of the eight data bytes is 0x2A
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    run_load("nominal", 1'b0, 0);
    chk("model_csum_pin", {24'd0, model_cs}, 32'h2A);
    if (la.size() == 2 && lb.size() == 2) begin
      chk("pin_a0_sr",   la[0].a, 32'd0);
      chk("pin_a0_data", la[0].d, 32'h12345678);
      chk("pin_a1_sr",   la[1].a, 32'd1);
      chk("pin_a1_data", la[1].d, 32'hDEADBEEF);
      chk("pin_b1_sr",   lb[1].a, 32'd1023);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL nominal_log_size: got %0d writes, expected 2", la.size());
    end

    // Bad checksum, restarted from DONE: words still land, load flagged
    stream[10] = 8'h89;
    run_load("badcsum", 1'b0, 0);

    // Length errors, restarted from ERR
    stream = '{8'h00, 8'h00};
    run_load("len0", 1'b0, 0);
    stream = '{8'h01, 8'h04};
    run_load("len1025", 1'b0, 0);

    // Stalls on the byte link
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    run_load("stall", 1'b0, 3);

    // Three words: base-1022 loader wraps 1022, 1023, 0; start while busy is ignored
    stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCC};
    run_load("wrap", 1'b1, 1);
    chk("wrap_csum_pin", {24'd0, model_cs}, 32'hCC);
    if (lb.size() == 3) begin
      chk("wrap_b0_sr",   lb[0].a, 32'd1022);
      chk("wrap_b1_sr",   lb[1].a, 32'd1023);
      chk("wrap_b2_sr",   lb[2].a, 32'd0);
      chk("wrap_b2_data", lb[2].d, 32'hCCBBAA99);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL wrap_log_size: got %0d writes, expected 3", lb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
